sprite_compositor: RTL

//  Parametrised, pipelined per-pixel compositor for the VGA game display. It replaces the

---
 rtl/sprite_compositor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
// Three-stage per-pixel sprite compositor: hit test and ROM addressing, opacity resolve,
// fixed-priority mux over a border/field background, plus sticky collisions against sprite 0.
module sprite_compositor #(
  parameter int          NUM_SPRITES = 8,
  parameter int          X_W         = 11,
  parameter int          Y_W         = 10,
  parameter int          HALF_W      = 7,
  parameter int          ADDR_W      = 12,
  parameter int          STRIDE_LOG2 = 5,
  parameter int          SCREEN_W    = 1440,
  parameter int          SCREEN_H    = 900,
  parameter int          BORDER      = 11,
  parameter logic [11:0] BORDER_RGB  = 12'h105,
  parameter logic [11:0] FIELD_RGB   = 12'h32A,
  parameter logic [11:0] TRANSP_KEY  = 12'h000,
  localparam int         HID_W       = $clog2(NUM_SPRITES) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic                          frame_start,
  input  logic [X_W-1:0]                draw_x,
  input  logic [Y_W-1:0]                draw_y,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  input  logic [NUM_SPRITES-1:0]        spr_mode,
  input  logic [NUM_SPRITES*X_W-1:0]    spr_x,
  input  logic [NUM_SPRITES*Y_W-1:0]    spr_y,
  input  logic [NUM_SPRITES*HALF_W-1:0] spr_hw,
  input  logic [NUM_SPRITES*HALF_W-1:0] spr_hh,
  input  logic [NUM_SPRITES*12-1:0]     spr_color,
  output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
  input  logic [NUM_SPRITES*12-1:0]     rom_data,
  output logic [3:0]                    r,
  output logic [3:0]                    g,
  output logic [3:0]                    b,
  output logic                          out_valid,
  output logic [HID_W-1:0]              hit_id,
  output logic [NUM_SPRITES-1:0]        coll_flags
);

  // Two guard bits keep x-hw below zero and x+hw above the coordinate range representable.
  localparam int XS_W = X_W + 2;
  localparam int YS_W = Y_W + 2;

  localparam logic [HID_W-1:0] HID_BG = {HID_W{1'b1}};
  localparam logic [X_W-1:0]   X_BLO  = X_W'(BORDER);
  localparam logic [X_W-1:0]   X_BHI  = X_W'(SCREEN_W - BORDER);
  localparam logic [Y_W-1:0]   Y_BLO  = Y_W'(BORDER);
  localparam logic [Y_W-1:0]   Y_BHI  = Y_W'(SCREEN_H - BORDER);

  logic [NUM_SPRITES-1:0]        hit_s;
  logic [NUM_SPRITES*ADDR_W-1:0] addr_s;
  logic                          border_s;

  logic                          valid1_r, fs1_r, border1_r;
  logic [NUM_SPRITES-1:0]        hit1_r, mode1_r;
  logic [NUM_SPRITES*12-1:0]     color1_r;

  logic                          valid2_r, fs2_r, border2_r;
  logic [NUM_SPRITES-1:0]        hit2_r, mode2_r;
  logic [NUM_SPRITES*12-1:0]     color2_r;

  logic [NUM_SPRITES-1:0]        opaque_s;
  logic [NUM_SPRITES*12-1:0]     col_s;
  logic [NUM_SPRITES-1:0]        coll_new_s;
  logic [HID_W-1:0]              win_id_s;
  logic [11:0]                   win_rgb_s;

  assign border_s = (draw_x < X_BLO) | (draw_x >= X_BHI) |
                    (draw_y < Y_BLO) | (draw_y >= Y_BHI);

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
    logic signed [XS_W-1:0] px_s, cx_s, hwx_s, lox_s, hix_s, dx_s;
    logic signed [YS_W-1:0] py_s, cy_s, hhy_s, loy_s, hiy_s, dy_s;

    assign px_s  = $signed({2'b00, draw_x});
    assign cx_s  = $signed({2'b00, spr_x[gi*X_W +: X_W]});
    assign hwx_s = $signed({{(XS_W-HALF_W){1'b0}}, spr_hw[gi*HALF_W +: HALF_W]});
    assign lox_s = cx_s - hwx_s;
    assign hix_s = cx_s + hwx_s;
    assign dx_s  = px_s - lox_s;

    assign py_s  = $signed({2'b00, draw_y});
    assign cy_s  = $signed({2'b00, spr_y[gi*Y_W +: Y_W]});
    assign hhy_s = $signed({{(YS_W-HALF_W){1'b0}}, spr_hh[gi*HALF_W +: HALF_W]});
    assign loy_s = cy_s - hhy_s;
    assign hiy_s = cy_s + hhy_s;
    assign dy_s  = py_s - loy_s;

    // Strict bounds: the sprite spans centre-half+1 .. centre+half-1.
    assign hit_s[gi] = spr_en[gi] & (px_s > lox_s) & (px_s < hix_s) &
                       (py_s > loy_s) & (py_s < hiy_s);
    assign addr_s[gi*ADDR_W +: ADDR_W] = (ADDR_W'(dy_s) << STRIDE_LOG2) + ADDR_W'(dx_s);

    // ROM data lines up with the S2 registers, one cycle after rom_addr.
    assign opaque_s[gi] = hit2_r[gi] &
                          (~mode2_r[gi] | (rom_data[gi*12 +: 12] != TRANSP_KEY));
    assign col_s[gi*12 +: 12] = mode2_r[gi] ? rom_data[gi*12 +: 12] : color2_r[gi*12 +: 12];
  end

  assign coll_new_s[0] = 1'b0;
  for (genvar gc = 1; gc < NUM_SPRITES; gc++) begin : g_coll
    assign coll_new_s[gc] = opaque_s[0] & opaque_s[gc];
  end

  // Fixed priority: later (higher-index) opaque sprites override earlier ones.
  always_comb begin
    win_id_s  = HID_BG;
    win_rgb_s = border2_r ? BORDER_RGB : FIELD_RGB;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      win_id_s  = opaque_s[i] ? HID_W'(i) : win_id_s;
      win_rgb_s = opaque_s[i] ? col_s[i*12 +: 12] : win_rgb_s;
    end
  end

  // S1: sample pixel and sprite state, register hit flags and ROM addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_r  <= 1'b0;
      fs1_r     <= 1'b0;
      border1_r <= 1'b0;
      hit1_r    <= {NUM_SPRITES{1'b0}};
      mode1_r   <= {NUM_SPRITES{1'b0}};
      color1_r  <= {(NUM_SPRITES*12){1'b0}};
      rom_addr  <= {(NUM_SPRITES*ADDR_W){1'b0}};
    end else begin
      valid1_r  <= pix_valid;
      fs1_r     <= frame_start;
      border1_r <= border_s;
      hit1_r    <= hit_s;
      mode1_r   <= spr_mode;
      color1_r  <= spr_color;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (hit_s[i]) begin
          rom_addr[i*ADDR_W +: ADDR_W] <= addr_s[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // S2: carry per-sprite attributes alongside the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid2_r  <= 1'b0;
      fs2_r     <= 1'b0;
      border2_r <= 1'b0;
      hit2_r    <= {NUM_SPRITES{1'b0}};
      mode2_r   <= {NUM_SPRITES{1'b0}};
      color2_r  <= {(NUM_SPRITES*12){1'b0}};
    end else begin
      valid2_r  <= valid1_r;
      fs2_r     <= fs1_r;
      border2_r <= border1_r;
      hit2_r    <= hit1_r;
      mode2_r   <= mode1_r;
      color2_r  <= color1_r;
    end
  end

  // S3: register composited colour, winner id and sticky collision flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r, g, b}  <= 12'h000;
      out_valid  <= 1'b0;
      hit_id     <= HID_BG;
      coll_flags <= {NUM_SPRITES{1'b0}};
    end else begin
      out_valid <= valid2_r;
      if (valid2_r) begin
        {r, g, b} <= win_rgb_s;
        hit_id    <= win_id_s;
      end else begin
        {r, g, b} <= 12'h000;
        hit_id    <= HID_BG;
      end
      // Frame start clears first, so that pixel's own collisions survive.
      coll_flags <= (fs2_r ? {NUM_SPRITES{1'b0}} : coll_flags) |
                    (valid2_r ? coll_new_s : {NUM_SPRITES{1'b0}});
    end
  end

endmodule
